// File: rtl/fpga_mem_responder_if.sv
// ---------------------------------------------------------------------------
// fpga_mem_responder_if
//   Handshake bundle between the FPGA memory responder and the two link FIFOs.
//   The shared 34-bit address/data bus is a bidirectional net and is carried
//   as a separate inout port on the responder.
//
//   empty_CPU_to_FPGA_FIFO  FIFO -> responder   1 = no request packet available
//   full_FPGA_to_CPU_FIFO   FIFO -> responder   1 = response FIFO cannot accept
//   r_en_CPU_to_FPGA_FIFO   responder -> FIFO   pop strobe (bus valid next cycle)
//   w_en_FPGA_to_CPU_FIFO   responder -> FIFO   push strobe (bus valid same cycle)
//
//   modport slave  : the responder side
//   modport master : the FIFO / link side
// ---------------------------------------------------------------------------
interface fpga_mem_responder_if;
    logic empty_CPU_to_FPGA_FIFO;
    logic full_FPGA_to_CPU_FIFO;
    logic r_en_CPU_to_FPGA_FIFO;
    logic w_en_FPGA_to_CPU_FIFO;

    modport slave (
        input  empty_CPU_to_FPGA_FIFO,
        input  full_FPGA_to_CPU_FIFO,
        output r_en_CPU_to_FPGA_FIFO,
        output w_en_FPGA_to_CPU_FIFO
    );

    modport master (
        output empty_CPU_to_FPGA_FIFO,
        output full_FPGA_to_CPU_FIFO,
        input  r_en_CPU_to_FPGA_FIFO,
        input  w_en_FPGA_to_CPU_FIFO
    );
endinterface

// File: rtl/fpga_mem_responder.sv
// ---------------------------------------------------------------------------
// fpga_mem_responder
//   FPGA-side responder for the CPU<->FPGA FIFO link. Pops request packets
//   from the CPU->FPGA FIFO, services them from an internal word-addressed
//   memory and returns read lines as bursts of 32-bit words into the
//   FPGA->CPU FIFO.
//
//   Packet meta [33:32]: 01 read req, 10 write req, 11 write data,
//                        00 read response.
//
//   Ports
//     clk               clock (single domain)
//     rst               asynchronous reset, active low
//     link              FIFO handshake bundle (slave modport)
//     address_data_bus  34-bit shared bus, driven here only while pushing
//     busy              1 whenever the FSM is not IDLE
//     proto_err         sticky flag for undecodable packets, cleared by reset
// ---------------------------------------------------------------------------
module fpga_mem_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int LINE_WORDS = 8,
    parameter int RD_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fpga_mem_responder_if.slave  link,
    inout  wire  [33:0]          address_data_bus,
    output logic                 busy,
    output logic                 proto_err
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int BW    = $clog2(LINE_WORDS);
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] META_RD_RSP  = 2'b00;
    localparam logic [1:0] META_RD_REQ  = 2'b01;
    localparam logic [1:0] META_WR_REQ  = 2'b10;
    localparam logic [1:0] META_WR_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WR_POP,
        WR_CAP,
        RD_WAIT,
        RD_SEND
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [AW-BW-1:0]    line_q;
    logic [BW-1:0]       beat_q;
    logic [LAT_W-1:0]    lat_q;
    logic                err_q;

    logic [31:0]         mem [MEM_WORDS];
    logic [AW-1:0]       mem_idx;
    logic [31:0]         rd_word;

    logic [33:0]         bus_in;
    logic [1:0]          meta;
    logic [AW-BW-1:0]    req_line;
    logic                last_beat;
    logic                r_en;
    logic                w_en;
    logic                unused_bus_bits;

    assign bus_in    = address_data_bus;
    assign meta      = bus_in[33:32];
    // Byte address -> word index modulo MEM_WORDS, with the in-line word bits
    // dropped so every request lands on an aligned line.
    assign req_line  = bus_in[AW+1:BW+2];
    assign last_beat = (beat_q == BW'(LINE_WORDS - 1));

    // Concatenating line and beat makes line+beat wrap modulo MEM_WORDS.
    assign mem_idx   = {line_q, beat_q};
    assign rd_word   = mem[mem_idx];

    assign unused_bus_bits = ^{bus_in[31:AW+2], bus_in[BW+1:0]};

    // The bus is only ever driven in push cycles; pop/capture cycles leave it
    // free for the request FIFO.
    assign address_data_bus = w_en ? {META_RD_RSP, rd_word} : 34'bz;

    assign link.r_en_CPU_to_FPGA_FIFO = r_en;
    assign link.w_en_FPGA_to_CPU_FIFO = w_en;
    assign proto_err = err_q;

    // State and datapath registers. The latency counter is loaded one short
    // because the capture cycle itself counts toward the read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                CAPTURE: begin
                    if (meta == META_RD_REQ || meta == META_WR_REQ) begin
                        line_q <= req_line;
                        beat_q <= '0;
                    end
                    if (meta == META_RD_REQ) begin
                        lat_q <= LAT_W'(RD_LATENCY - 1);
                    end
                    if (meta == META_RD_RSP || meta == META_WR_DATA) begin
                        err_q <= 1'b1;
                    end
                end
                WR_CAP: begin
                    if (meta == META_WR_DATA) begin
                        beat_q <= beat_q + BW'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                end
                RD_SEND: begin
                    if (w_en) begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing memory; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (state_q == WR_CAP && meta == META_WR_DATA) begin
            mem[mem_idx] <= bus_in[31:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!link.empty_CPU_to_FPGA_FIFO) state_d = CAPTURE;
            end
            CAPTURE: begin
                case (meta)
                    META_RD_REQ: state_d = (RD_LATENCY == 1) ? RD_SEND : RD_WAIT;
                    META_WR_REQ: state_d = WR_POP;
                    default:     state_d = IDLE;
                endcase
            end
            WR_POP: begin
                if (!link.empty_CPU_to_FPGA_FIFO) state_d = WR_CAP;
            end
            WR_CAP: begin
                if (meta == META_WR_DATA && !last_beat) state_d = WR_POP;
                else                                     state_d = IDLE;
            end
            RD_WAIT: begin
                if (lat_q <= LAT_W'(1)) state_d = RD_SEND;
            end
            RD_SEND: begin
                if (!link.full_FPGA_to_CPU_FIFO && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output strobes. Gating with rst keeps the pop strobe quiet while reset
    // is held even if requests are waiting.
    always_comb begin
        r_en = 1'b0;
        w_en = 1'b0;
        busy = (state_q != IDLE);
        if (rst) begin
            case (state_q)
                IDLE, WR_POP: r_en = !link.empty_CPU_to_FPGA_FIFO;
                RD_SEND:      w_en = !link.full_FPGA_to_CPU_FIFO;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_fpga_mem_responder
//   Directed bench for fpga_mem_responder. A small queue models the
//   CPU->FPGA FIFO (pops on r_en, drives the bus in the following cycle) and
//   a second queue records every pushed response word with its cycle number.
//   While the responder is expected to float the bus, the bench drives zero
//   onto it so any stray drive from the responder shows up as a bad value.
// ---------------------------------------------------------------------------
module tb_fpga_mem_responder;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        full       = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        drv_en     = 1'b0;
    logic [33:0] drv_val    = '0;
    logic        probe      = 1'b0;
    wire  [33:0] address_data_bus;
    logic        busy;
    logic        proto_err;

    logic [33:0] req_q[$];
    logic [33:0] rsp_q[$];
    int          push_cyc[$];
    int          cyc          = 0;
    int          last_ren_cyc = -1;
    int          n_checks     = 0;
    int          n_pass       = 0;
    int          n_fail       = 0;

    logic [31:0] exp_a [8];
    logic [31:0] exp_c [8];

    fpga_mem_responder_if link();

    assign link.empty_CPU_to_FPGA_FIFO = fifo_empty;
    assign link.full_FPGA_to_CPU_FIFO  = full;
    assign address_data_bus = drv_en ? drv_val : (probe ? 34'h0 : 34'bz);

    fpga_mem_responder #(
        .MEM_WORDS (4096),
        .LINE_WORDS(8),
        .RD_LATENCY(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .link            (link),
        .address_data_bus(address_data_bus),
        .busy            (busy),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    // Request FIFO model: a pop in cycle N puts the packet on the bus in N+1.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        drv_en <= 1'b0;
        if (link.r_en_CPU_to_FPGA_FIFO && req_q.size() > 0) begin
            drv_val <= req_q.pop_front();
            drv_en  <= 1'b1;
        end
        fifo_empty <= (req_q.size() == 0);
    end

    // Response FIFO model plus pop-cycle tracking for latency checks.
    always @(negedge clk) begin
        if (link.r_en_CPU_to_FPGA_FIFO) last_ren_cyc = cyc;
        if (link.w_en_FPGA_to_CPU_FIFO) begin
            rsp_q.push_back(address_data_bus);
            push_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [1:0] meta, input logic [31:0] data);
        req_q.push_back({meta, data});
    endtask

    task automatic clear_rsp();
        rsp_q.delete();
        push_cyc.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check_output(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_burst(input string tag, input logic [31:0] exp [8]);
        check_output({tag, "_count"}, 64'(rsp_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            check_output($sformatf("%s_word%0d", tag, i), 64'(rsp_q[i]), 64'({2'b00, exp[i]}));
        end
    endtask

    task automatic write_line(input logic [31:0] addr, input logic [31:0] base);
        push_pkt(2'b10, addr);
        for (int i = 0; i < 8; i++) push_pkt(2'b11, base + 32'(i));
        step(2);
        wait_idle("write_line_idle", 60);
    endtask

    task automatic read_line(input string tag, input logic [31:0] addr, input logic [31:0] exp [8]);
        clear_rsp();
        push_pkt(2'b01, addr);
        step(2);
        wait_idle({tag, "_idle"}, 60);
        check_burst(tag, exp);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 32'hA0 + 32'(i);
            exp_c[i] = 32'hB0 + 32'(i);
        end
        exp_c[0] = 32'hC0;
        exp_c[1] = 32'hC1;

        // Reset state
        step(2);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_err", 64'(proto_err), 64'd0);
        check_output("rst_wen", 64'(link.w_en_FPGA_to_CPU_FIFO), 64'd0);
        check_output("rst_ren", 64'(link.r_en_CPU_to_FPGA_FIFO), 64'd0);
        rst = 1'b1;
        step(2);
        check_output("post_rst_busy", 64'(busy), 64'd0);

        // Test 1: full line write to 0x40 -> words 16..23
        $display("[TB] write line 0x40");
        clear_rsp();
        push_pkt(2'b10, 32'h0000_0040);
        for (int i = 0; i < 8; i++) push_pkt(2'b11, 32'hA0 + 32'(i));
        step(18);
        check_output("t1_busy_last_beat", 64'(busy), 64'd1);
        step(1);
        check_output("t1_busy_after", 64'(busy), 64'd0);
        check_output("t1_no_push", 64'(rsp_q.size()), 64'd0);
        check_output("t1_err", 64'(proto_err), 64'd0);

        // Test 2: read from 0x44 returns the aligned line, latency 5 from pop
        $display("[TB] read line 0x44");
        read_line("t2", 32'h0000_0044, exp_a);
        if (push_cyc.size() == 8) begin
            check_output("t2_latency", 64'(push_cyc[0] - last_ren_cyc), 64'd5);
            check_output("t2_rate", 64'(push_cyc[7] - push_cyc[0]), 64'd7);
        end else begin
            check_output("t2_push_count", 64'(push_cyc.size()), 64'd8);
        end

        // Test 3: response FIFO full for 3 cycles at beat 3
        $display("[TB] read with backpressure");
        clear_rsp();
        push_pkt(2'b01, 32'h0000_0040);
        step(9);
        full  = 1'b1;
        probe = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #1;
            check_output($sformatf("t3_hold%0d_wen", h), 64'(link.w_en_FPGA_to_CPU_FIFO), 64'd0);
            check_output($sformatf("t3_hold%0d_bus", h), 64'(address_data_bus), 64'd0);
            check_output($sformatf("t3_hold%0d_cnt", h), 64'(rsp_q.size()), 64'd3);
            step(1);
        end
        full  = 1'b0;
        probe = 1'b0;
        wait_idle("t3_idle", 40);
        check_burst("t3", exp_a);
        if (push_cyc.size() == 8) begin
            check_output("t3_span", 64'(push_cyc[7] - push_cyc[0]), 64'd10);
        end

        // Test 5: write aborted by a read-request packet at beat 2.
        // 0x4080 aliases to word 32 because the index wraps modulo 4096.
        $display("[TB] aborted write");
        write_line(32'h0000_0080, 32'hB0);
        check_output("t5_err_before", 64'(proto_err), 64'd0);
        clear_rsp();
        push_pkt(2'b10, 32'h0000_4080);
        push_pkt(2'b11, 32'hC0);
        push_pkt(2'b11, 32'hC1);
        push_pkt(2'b01, 32'h0000_0080);
        step(2);
        wait_idle("t5_idle", 40);
        check_output("t5_err", 64'(proto_err), 64'd1);
        check_output("t5_no_push", 64'(rsp_q.size()), 64'd0);
        check_output("t5_req_drained", 64'(req_q.size()), 64'd0);
        read_line("t5", 32'h0000_0080, exp_c);

        // Test 6: async reset at read beat 4
        $display("[TB] reset mid-read");
        clear_rsp();
        push_pkt(2'b01, 32'h0000_0040);
        step(10);
        check_output("t6_pre_wen", 64'(link.w_en_FPGA_to_CPU_FIFO), 64'd1);
        check_output("t6_pre_cnt", 64'(rsp_q.size()), 64'd4);
        rst   = 1'b0;
        probe = 1'b1;
        #1;
        check_output("t6_wen", 64'(link.w_en_FPGA_to_CPU_FIFO), 64'd0);
        check_output("t6_bus", 64'(address_data_bus), 64'd0);
        check_output("t6_busy", 64'(busy), 64'd0);
        step(2);
        check_output("t6_cnt_held", 64'(rsp_q.size()), 64'd4);
        rst   = 1'b1;
        probe = 1'b0;
        step(2);
        check_output("t6_busy_after", 64'(busy), 64'd0);
        check_output("t6_err_cleared", 64'(proto_err), 64'd0);
        read_line("t6", 32'h0000_0040, exp_a);

        // Test 4: write-data packet while idle
        $display("[TB] stray write-data packet");
        clear_rsp();
        push_pkt(2'b11, 32'h1234_5678);
        step(2);
        check_output("t4_err_pre", 64'(proto_err), 64'd0);
        check_output("t4_busy_cap", 64'(busy), 64'd1);
        step(1);
        check_output("t4_err", 64'(proto_err), 64'd1);
        check_output("t4_busy", 64'(busy), 64'd0);
        read_line("t4", 32'h0000_005C, exp_a);
        check_output("t4_err_sticky", 64'(proto_err), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
